// File: rtl/mod_148_4_cmd_codec.sv
// ----------------------------------------------------------------------------
// mod_148_4_cmd_codec
// MII-side command codec for the PLCA control channel, one per node.
//   TX: muxes MAC data or a BEACON/COMMIT command symbol onto TXD/TX_EN/TX_ER.
//   RX: qualifies repeated command nibbles into rx_cmd, tracks frame
//       reception, and strips command symbols from the MAC receive path.
// Ports:
//   clk, plca_reset                   nibble clock, synchronous active-high reset
//   tx_cmd, mac_txd/tx_en/tx_er       TX command and MAC transmit data
//   TXD, TX_EN, TX_ER                 PHY transmit (registered)
//   RXD, RX_DV, RX_ER                 PHY receive
//   rx_cmd, receiving, rx_cmd_err     decoded receive status (registered)
//   mac_rxd, mac_rx_dv, mac_rx_er     MAC receive path, commands stripped (registered)
// ----------------------------------------------------------------------------
module mod_148_4_cmd_codec #(
    parameter int unsigned CMD_QUAL = 2,
    parameter int unsigned QUAL_W   = 4
) (
    input  logic       clk,
    input  logic       plca_reset,
    input  logic [1:0] tx_cmd,
    input  logic [3:0] mac_txd,
    input  logic       mac_tx_en,
    input  logic       mac_tx_er,
    output logic [3:0] TXD,
    output logic       TX_EN,
    output logic       TX_ER,
    input  logic [3:0] RXD,
    input  logic       RX_DV,
    input  logic       RX_ER,
    output logic [1:0] rx_cmd,
    output logic       receiving,
    output logic [3:0] mac_rxd,
    output logic       mac_rx_dv,
    output logic       mac_rx_er,
    output logic       rx_cmd_err
);

    localparam logic [1:0] CMD_BEACON = 2'b00;
    localparam logic [1:0] CMD_COMMIT = 2'b01;
    localparam logic [1:0] CMD_NONE   = 2'b10;

    localparam logic [QUAL_W-1:0] QUAL_MAX = QUAL_W'(CMD_QUAL);
    localparam logic              QUAL_ONE = (CMD_QUAL <= 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_QUAL,
        RX_CMD,
        RX_DATA
    } rx_state_e;

    rx_state_e         state_q, state_d;
    logic [QUAL_W-1:0] cnt_q, cnt_d;
    logic [1:0]        pat_q, pat_d;

    logic [3:0] txd_q, txd_d;
    logic       tx_en_q, tx_en_d;
    logic       tx_er_q, tx_er_d;
    logic [1:0] rx_cmd_q, rx_cmd_d;
    logic       receiving_q, receiving_d;
    logic [3:0] mac_rxd_q, mac_rxd_d;
    logic       mac_rx_dv_q, mac_rx_dv_d;
    logic       mac_rx_er_q, mac_rx_er_d;
    logic       rx_cmd_err_q, rx_cmd_err_d;

    // Receive symbol classification (only meaningful outside a frame)
    logic       is_bcn, is_cmt, is_cmd, is_bad;
    logic [1:0] rx_pat;
    logic [QUAL_W-1:0] cnt_inc;

    always_comb begin
        is_bcn  = !RX_DV && RX_ER && (RXD == 4'h2);
        is_cmt  = !RX_DV && RX_ER && (RXD == 4'h3);
        is_cmd  = is_bcn || is_cmt;
        is_bad  = !RX_DV && RX_ER && !is_cmd;
        rx_pat  = is_cmt ? CMD_COMMIT : CMD_BEACON;
        cnt_inc = (cnt_q >= QUAL_MAX) ? QUAL_MAX : cnt_q + QUAL_W'(1);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pat_d        = pat_q;
        txd_d        = mac_txd;
        tx_en_d      = 1'b0;
        tx_er_d      = mac_tx_er;
        rx_cmd_d     = CMD_NONE;
        receiving_d  = 1'b0;
        mac_rxd_d    = RXD;
        mac_rx_dv_d  = RX_DV;
        mac_rx_er_d  = RX_ER;
        rx_cmd_err_d = is_bad;

        // TX encode: MAC data has priority over any command
        if (mac_tx_en) begin
            tx_en_d = 1'b1;
        end else if (tx_cmd == CMD_BEACON) begin
            txd_d   = 4'h2;
            tx_er_d = 1'b1;
        end else if (tx_cmd == CMD_COMMIT) begin
            txd_d   = 4'h3;
            tx_er_d = 1'b1;
        end

        // RX FSM; a new or different command always restarts qualification
        if (RX_DV) begin
            state_d = RX_DATA;
            cnt_d   = '0;
        end else if (is_cmd) begin
            if ((state_q == RX_QUAL || state_q == RX_CMD) && rx_pat == pat_q) begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc >= QUAL_MAX) ? RX_CMD : RX_QUAL;
            end else begin
                cnt_d   = QUAL_W'(1);
                pat_d   = rx_pat;
                state_d = QUAL_ONE ? RX_CMD : RX_QUAL;
            end
        end else begin
            state_d = RX_IDLE;
            cnt_d   = '0;
        end

        if (state_d == RX_CMD) begin
            rx_cmd_d = pat_d;
        end
        receiving_d = (state_d == RX_DATA);

        // Command symbols never reach the MAC
        if (is_cmd) begin
            mac_rxd_d   = 4'h0;
            mac_rx_dv_d = 1'b0;
            mac_rx_er_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (plca_reset) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            pat_q        <= CMD_BEACON;
            txd_q        <= 4'h0;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            rx_cmd_q     <= CMD_NONE;
            receiving_q  <= 1'b0;
            mac_rxd_q    <= 4'h0;
            mac_rx_dv_q  <= 1'b0;
            mac_rx_er_q  <= 1'b0;
            rx_cmd_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pat_q        <= pat_d;
            txd_q        <= txd_d;
            tx_en_q      <= tx_en_d;
            tx_er_q      <= tx_er_d;
            rx_cmd_q     <= rx_cmd_d;
            receiving_q  <= receiving_d;
            mac_rxd_q    <= mac_rxd_d;
            mac_rx_dv_q  <= mac_rx_dv_d;
            mac_rx_er_q  <= mac_rx_er_d;
            rx_cmd_err_q <= rx_cmd_err_d;
        end
    end

    assign TXD        = txd_q;
    assign TX_EN      = tx_en_q;
    assign TX_ER      = tx_er_q;
    assign rx_cmd     = rx_cmd_q;
    assign receiving  = receiving_q;
    assign mac_rxd    = mac_rxd_q;
    assign mac_rx_dv  = mac_rx_dv_q;
    assign mac_rx_er  = mac_rx_er_q;
    assign rx_cmd_err = rx_cmd_err_q;

endmodule

// File: tb/tb_mod_148_4_cmd_codec.sv
// ----------------------------------------------------------------------------
// tb_mod_148_4_cmd_codec
// Table of {inputs, expected outputs} rows applied one per clock; each row's
// expectation is queued when driven and compared one edge later.
// ----------------------------------------------------------------------------
module tb_mod_148_4_cmd_codec;

    typedef struct {
        string       name;
        logic        rst;
        logic [1:0]  txc;
        logic [3:0]  mtxd;
        logic        men;
        logic        mer;
        logic [3:0]  rxd;
        logic        dv;
        logic        er;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;

    logic       clk = 1'b0;
    logic       plca_reset;
    logic [1:0] tx_cmd;
    logic [3:0] mac_txd;
    logic       mac_tx_en, mac_tx_er;
    logic [3:0] TXD;
    logic       TX_EN, TX_ER;
    logic [3:0] RXD;
    logic       RX_DV, RX_ER;
    logic [1:0] rx_cmd;
    logic       receiving;
    logic [3:0] mac_rxd;
    logic       mac_rx_dv, mac_rx_er, rx_cmd_err;

    int total = 0;
    int bad   = 0;

    vec_t tbl[$];
    sb_t  sb[$];

    always #5 clk = ~clk;

    mod_148_4_cmd_codec #(.CMD_QUAL(2), .QUAL_W(4)) dut (
        .clk        (clk),
        .plca_reset (plca_reset),
        .tx_cmd     (tx_cmd),
        .mac_txd    (mac_txd),
        .mac_tx_en  (mac_tx_en),
        .mac_tx_er  (mac_tx_er),
        .TXD        (TXD),
        .TX_EN      (TX_EN),
        .TX_ER      (TX_ER),
        .RXD        (RXD),
        .RX_DV      (RX_DV),
        .RX_ER      (RX_ER),
        .rx_cmd     (rx_cmd),
        .receiving  (receiving),
        .mac_rxd    (mac_rxd),
        .mac_rx_dv  (mac_rx_dv),
        .mac_rx_er  (mac_rx_er),
        .rx_cmd_err (rx_cmd_err)
    );

    // Packing order: TXD,TX_EN,TX_ER,rx_cmd,receiving,mac_rxd,mac_rx_dv,mac_rx_er,rx_cmd_err
    function automatic logic [15:0] pk(int txd, int ten, int ter, int rc, int rcv,
                                       int mrxd, int mdv, int mer, int err);
        return {4'(txd), 1'(ten), 1'(ter), 2'(rc), 1'(rcv),
                4'(mrxd), 1'(mdv), 1'(mer), 1'(err)};
    endfunction

    // RX-side row; TX inputs idle (tx_cmd NONE, no MAC data) so TX outputs are 0
    function automatic vec_t rv(string n, int rst, int rxd, int dv, int er,
                                int rc, int rcv, int mrxd, int mdv, int mer, int err);
        vec_t v;
        v.name = n;   v.rst = 1'(rst);
        v.txc  = 2'b10; v.mtxd = 4'h0; v.men = 1'b0; v.mer = 1'b0;
        v.rxd  = 4'(rxd); v.dv = 1'(dv); v.er = 1'(er);
        v.exp  = pk(0, 0, 0, rc, rcv, mrxd, mdv, mer, err);
        return v;
    endfunction

    // TX-side row; RX idle, so RX outputs stay at idle values
    function automatic vec_t tv(string n, int txc, int mtxd, int men, int mer,
                                int etxd, int eten, int eter);
        vec_t v;
        v.name = n;   v.rst = 1'b0;
        v.txc  = 2'(txc); v.mtxd = 4'(mtxd); v.men = 1'(men); v.mer = 1'(mer);
        v.rxd  = 4'h0; v.dv = 1'b0; v.er = 1'b0;
        v.exp  = pk(etxd, eten, eter, 2, 0, 0, 0, 0, 0);
        return v;
    endfunction

    // Reference TX priority encoder for the randomized TX rows
    function automatic vec_t tx_ref(int txc, int mtxd, int men, int mer);
        if (men != 0)      return tv("tx_rand", txc, mtxd, men, mer, mtxd, 1, mer);
        else if (txc == 0) return tv("tx_rand", txc, mtxd, men, mer, 2, 0, 1);
        else if (txc == 1) return tv("tx_rand", txc, mtxd, men, mer, 3, 0, 1);
        else               return tv("tx_rand", txc, mtxd, men, mer, mtxd, 0, mer);
    endfunction

    task automatic drive(input vec_t v);
        sb_t s;
        @(negedge clk);
        plca_reset = v.rst;
        tx_cmd     = v.txc;
        mac_txd    = v.mtxd;
        mac_tx_en  = v.men;
        mac_tx_er  = v.mer;
        RXD        = v.rxd;
        RX_DV      = v.dv;
        RX_ER      = v.er;
        s.name = v.name;
        s.exp  = v.exp;
        sb.push_back(s);
    endtask

    task automatic check_out();
        sb_t         s;
        logic [15:0] act;
        act = {TXD, TX_EN, TX_ER, rx_cmd, receiving, mac_rxd, mac_rx_dv, mac_rx_er, rx_cmd_err};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: got=%h want=<queued entry>", act);
        end else begin
            s = sb.pop_front();
            if (act !== s.exp) begin
                bad++;
                $display("FAIL %s: got=%h want=%h", s.name, act, s.exp);
            end
        end
    endtask

    initial begin
        plca_reset = 1'b1;
        tx_cmd = 2'b10; mac_txd = 4'h0; mac_tx_en = 1'b0; mac_tx_er = 1'b0;
        RXD = 4'h0; RX_DV = 1'b0; RX_ER = 1'b0;

        // Reset held 3 clk with BCN on the wire, then released
        for (int i = 0; i < 3; i++) tbl.push_back(rv("reset", 1, 2, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(rv("post_reset_bcn", 0, 2, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(rv("idle0", 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));

        // BEACON x5: qualified from the 2nd output, counter saturates
        tbl.push_back(rv("bcn1", 0, 2, 0, 1, 2, 0, 0, 0, 0, 0));
        for (int i = 2; i <= 5; i++) tbl.push_back(rv("bcn_q", 0, 2, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(rv("bcn_end", 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));

        // Single CMT glitch then BCN x3
        tbl.push_back(rv("glitch_cmt", 0, 3, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(rv("glitch_bcn1", 0, 2, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(rv("glitch_bcn2", 0, 2, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(rv("glitch_bcn3", 0, 2, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(rv("glitch_end", 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));

        // COMMIT received, then an 8-nibble frame
        tbl.push_back(rv("cmt1", 0, 3, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(rv("cmt2", 0, 3, 0, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 8; i++) tbl.push_back(rv("frame", 0, i + 6, 1, 0, 2, 1, i + 6, 1, 0, 0));
        tbl.push_back(rv("frame_er", 0, 2, 1, 1, 2, 1, 2, 1, 1, 0));
        // DV drops on a CMT nibble: qualification starts, symbol stripped
        tbl.push_back(rv("dv_drop_cmt", 0, 3, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(rv("cmt_q", 0, 3, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(rv("cmd_switch", 0, 2, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(rv("switch_q", 0, 2, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(rv("bad_in_cmd", 0, 14, 0, 1, 2, 0, 14, 0, 1, 1));
        tbl.push_back(rv("idle1", 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));

        // BAD from idle: one-cycle error pulse, passed to MAC
        tbl.push_back(rv("bad_idle", 0, 14, 0, 1, 2, 0, 14, 0, 1, 1));
        tbl.push_back(rv("bad_clear", 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));

        // BAD during qualification restarts the count
        tbl.push_back(rv("q_bcn", 0, 2, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(rv("q_bad", 0, 15, 0, 1, 2, 0, 15, 0, 1, 1));
        tbl.push_back(rv("q_bcn_restart", 0, 2, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(rv("q_bcn_ok", 0, 2, 0, 1, 0, 0, 0, 0, 0, 0));

        // Reset mid-command leaves no residue
        tbl.push_back(rv("rst_mid_cmd", 1, 2, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(rv("rst_bcn1", 0, 2, 0, 1, 2, 0, 0, 0, 0, 0));
        tbl.push_back(rv("rst_bcn2", 0, 2, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(rv("idle2", 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));

        // Reset mid-frame
        tbl.push_back(rv("frame_a", 0, 5, 1, 0, 2, 1, 5, 1, 0, 0));
        tbl.push_back(rv("rst_mid_frame", 1, 6, 1, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(rv("idle3", 0, 0, 0, 0, 2, 0, 0, 0, 0, 0));

        // TX priority
        tbl.push_back(tv("tx_commit", 1, 0, 0, 0, 3, 0, 1));
        tbl.push_back(tv("tx_data_wins", 1, 5, 1, 0, 5, 1, 0));
        tbl.push_back(tv("tx_beacon", 0, 0, 0, 0, 2, 0, 1));
        tbl.push_back(tv("tx_none", 2, 10, 0, 1, 10, 0, 1));
        tbl.push_back(tv("tx_illegal", 3, 7, 0, 0, 7, 0, 0));
        tbl.push_back(tv("tx_err_data", 0, 12, 1, 1, 12, 1, 1));
        for (int i = 0; i < 24; i++)
            tbl.push_back(tx_ref(int'($urandom_range(3)), int'($urandom_range(15)),
                                 int'($urandom_range(1)), int'($urandom_range(1))));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check_out();
        end

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got=%0d leftover want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
